pipelined_ripple_carry_adder: RTL and testbench
===============================================

Name: pipelined_ripple_carry_adder

Overview:
- Parametrised, pipelined successor to the team's fixed-width ripple carry adders.
- Splits a WIDTH-bit add/subtract into STAGES equal ripple segments, with one register boundary per segment.
- Carries ripple between stages through registers. Operands and results are skew-aligned so one result leaves per cycle.
- Sits in datapaths that need wide adds at clock rates a single ripple chain cannot meet. Uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline stages and ripple segments; segment width SEG = WIDTH/STAGES; legal range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block accepts input this cycle.
- sub  input  1  0: a + b + cin; 1: a - b - cin (a + ~b + ~cin).
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of the MSB. Add: unsigned overflow. Sub: 1 = no borrow.
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0; out_valid 0, sum 0, cout 0, overflow 0. Pipeline contents are discarded. On reset release, in_ready is 1 on the first edge.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational; no dependency on in_valid).
- Accept: handshake when in_valid && in_ready.
  - At acceptance, register effective b (b XOR {WIDTH{sub}}), effective carry (cin XOR sub), a, and a valid bit into stage 0.
- Stage k (0..STAGES-1), when adv:
  - Add segment k of a and effective b plus the incoming registered carry.
  - Store the SEG-bit partial sum and carry-out into stage k+1 registers.
  - Forward untouched higher segments and already-computed lower sum segments unchanged.
  - Shift the valid bit along.
- When adv is 0, every stage register holds, including the valid bits. Bubbles are not compressed: the global stall is intentional.
- Latency: STAGES cycles from accepting edge to out_valid high, when not stalled. Throughput: one result per cycle.
- Output registers: sum, cout and overflow are the final-stage registers. They hold stable while out_valid && !out_ready.
- overflow: computed in the last segment from the carry into bit WIDTH-1 and cout.
- STAGES=1: the block degenerates to one registered WIDTH-bit ripple add with latency 1.
- Empty pipeline: out_valid 0. sum/cout/overflow retain the last values; consumers ignore them.
- Simultaneous accept and emit under back-pressure release: both occur on the same edge with no loss or duplication.
- Reset mid-operation: all in-flight transactions are dropped; none appear after reset release.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1: a=0x0F, b=0x01, sub=0, cin=0 -> after 2 cycles: sum=0x10, cout=0, overflow=0. This exercises the inter-stage carry.
- Same config: a=0x7F, b=0x01, add, cin=0 -> sum=0x80, cout=0, overflow=1. Then a=0xFF, b=0x01 -> sum=0x00, cout=1, overflow=0.
- Subtract: a=0x05, b=0x07, sub=1, cin=0 -> sum=0xFE, cout=0 (borrow). a=0x07, b=0x05, sub=1, cin=1 -> sum=0x01, cout=1.
- Default 32/4: stream 16 back-to-back random adds with out_ready=1 -> 16 results in order, one per cycle, first at cycle 4. Each matches a reference model including cout/overflow.
- Back-pressure: hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and sum held stable throughout. On release, results arrive in order with none dropped or duplicated.
- Assert rst_n low with 3 transactions in flight -> out_valid, sum, cout, overflow 0 immediately (asynchronous). After release, no stale result is emitted and a new add completes normally.

Source files
------------

// File: rtl/pipelined_ripple_carry_adder.sv
// Pipelined ripple-carry add/subtract: WIDTH bits split into STAGES ripple segments,
// one register boundary per segment, single global stall driven by the output handshake.
module pipelined_ripple_carry_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int unsigned SEG = WIDTH / STAGES;

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar g = 0; g < STAGES; g++) begin : gen_stage
        localparam int unsigned LO  = g * SEG;
        // x carries finished sum segments below LO and untouched A segments above
        localparam int unsigned REM = WIDTH - LO;

        logic [WIDTH-1:0] x_in;
        logic [WIDTH-1:0] x_d;
        logic [WIDTH-1:0] x_q;
        logic [REM-1:0]   b_in;
        logic             c_in;
        logic             v_in;
        logic             c_q;
        logic             v_q;
        logic [SEG:0]     seg_d;

        if (g == 0) begin : gen_in
            assign x_in = a;
            assign b_in = b ^ {WIDTH{sub}};
            assign c_in = cin ^ sub;
            assign v_in = in_valid;
        end else begin : gen_link
            assign x_in = gen_stage[g-1].x_q;
            assign b_in = gen_stage[g-1].gen_bq.b_q;
            assign c_in = gen_stage[g-1].c_q;
            assign v_in = gen_stage[g-1].v_q;
        end

        assign seg_d = {1'b0, x_in[LO +: SEG]} + {1'b0, b_in[SEG-1:0]} + (SEG+1)'(c_in);

        always_comb begin
            x_d            = x_in;
            x_d[LO +: SEG] = seg_d[SEG-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                x_q <= '0;
                c_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_in;
                if (v_in) begin
                    x_q <= x_d;
                    c_q <= seg_d[SEG];
                end
            end
        end

        if (g < STAGES - 1) begin : gen_bq
            logic [REM-SEG-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_q <= '0;
                end else if (adv && v_in) begin
                    b_q <= b_in[REM-1:SEG];
                end
            end
        end else begin : gen_last
            logic ovf_d;
            logic ovf_q;

            // carry into the MSB recovered as a ^ b ^ s at bit WIDTH-1
            assign ovf_d = seg_d[SEG] ^ x_in[WIDTH-1] ^ b_in[SEG-1] ^ seg_d[SEG-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv && v_in) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = gen_stage[STAGES-1].v_q;
    assign sum       = gen_stage[STAGES-1].x_q;
    assign cout      = gen_stage[STAGES-1].c_q;
    assign overflow  = gen_stage[STAGES-1].gen_last.ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_carry_adder.sv
// Directed bench for pipelined_ripple_carry_adder: an 8-bit/2-stage instance for
// hand-computed vectors and a default 32-bit/4-stage instance for streaming, stall and reset.
module tb_pipelined_ripple_carry_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic       iv8, ir8, sub8, cin8, ov8, or8, co8, of8;
    logic [7:0] a8, b8, s8;

    logic        iv32, ir32, sub32, cin32, ov32, or32, co32, of32;
    logic [31:0] a32, b32, s32;

    pipelined_ripple_carry_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .sub(sub8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(ov8), .out_ready(or8),
        .sum(s8), .cout(co8), .overflow(of8)
    );

    pipelined_ripple_carry_adder #(.WIDTH(32), .STAGES(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .sub(sub32),
        .a(a32), .b(b32), .cin(cin32), .out_valid(ov32), .out_ready(or32),
        .sum(s32), .cout(co32), .overflow(of32)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {overflow, cout, sum} from the two's-complement sign rule.
    function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic c);
        logic [31:0] be;
        logic        ce;
        logic [32:0] f;
        logic        v;
        be = s ? ~b : b;
        ce = c ^ s;
        f  = {1'b0, a} + {1'b0, be} + {32'd0, ce};
        v  = (a[31] == be[31]) && (f[31] != a[31]);
        return {v, f[32], f[31:0]};
    endfunction

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic c,
                        input logic [7:0] es, input logic ec, input logic ev);
        a8 = a; b8 = b; sub8 = s; cin8 = c; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        check_eq({tag, "_early"}, ov8, 0);
        @(posedge clk); #1;
        check_eq({tag, "_vld"}, ov8, 1);
        check_eq({tag, "_sum"}, s8, es);
        check_eq({tag, "_cout"}, co8, ec);
        check_eq({tag, "_ovf"}, of8, ev);
    endtask

    task automatic run_stream(input string tag, input int n, input logic allow_sub,
                              input int stall_at, input int stall_len);
        logic [33:0] expq[$];
        logic [33:0] e;
        int          sent  = 0;
        int          got   = 0;
        int          first = -1;
        int          last  = -1;
        for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
            or32 = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            if (!or32) begin
                check_eq({tag, "_stall_vld"}, ov32, 1);
                check_eq({tag, "_stall_rdy"}, ir32, 0);
                if (expq.size() > 0) check_eq({tag, "_stall_hold"}, s32, expq[0][31:0]);
            end
            if (ov32 && or32) begin
                if (expq.size() == 0) begin
                    check_eq({tag, "_extra"}, 1, 0);
                end else begin
                    e = expq.pop_front();
                    check_eq({tag, "_sum"}, s32, e[31:0]);
                    check_eq({tag, "_cout"}, co32, e[32]);
                    check_eq({tag, "_ovf"}, of32, e[33]);
                end
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (sent < n) begin
                a32   = $urandom();
                b32   = $urandom();
                sub32 = allow_sub ? 1'($urandom_range(0, 1)) : 1'b0;
                cin32 = 1'($urandom_range(0, 1));
                iv32  = 1'b1;
            end else begin
                iv32 = 1'b0;
            end
            #1;
            if (iv32 && ir32) begin
                expq.push_back(ref_add(a32, b32, sub32, cin32));
                sent++;
            end
            @(posedge clk); #1;
        end
        iv32 = 1'b0;
        or32 = 1'b1;
        check_eq({tag, "_count"}, got, n);
        check_eq({tag, "_first_lat"}, first, 4);
        check_eq({tag, "_last"}, last, 3 + n + stall_len);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq({tag, "_drain_idle"}, ov32, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int stale;
        rst_n = 1'b0;
        iv8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
        iv32 = 1'b0; sub32 = 1'b0; cin32 = 1'b0; a32 = '0; b32 = '0; or32 = 1'b1;
        #12;
        check_eq("rst_vld8", ov8, 0);
        check_eq("rst_sum8", s8, 0);
        check_eq("rst_vld32", ov32, 0);
        check_eq("rst_sum32", s32, 0);
        check_eq("rst_cout32", co32, 0);
        check_eq("rst_ovf32", of32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rel_rdy8", ir8, 1);
        check_eq("rel_rdy32", ir32, 1);

        run8("add_carry", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        run8("add_sovf",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run8("add_uovf",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run8("sub_borrow", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        run8("sub_bin",   8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
        run8("add_cin",   8'h80, 8'h80, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1);

        run_stream("stream", 16, 1'b0, 0, 0);
        run_stream("bp", 10, 1'b1, 6, 5);

        for (int i = 0; i < 3; i++) begin
            a32 = $urandom(); b32 = $urandom(); sub32 = 1'b0; cin32 = 1'b0; iv32 = 1'b1;
            #1;
            check_eq("inflight_rdy", ir32, 1);
            @(posedge clk); #1;
        end
        iv32 = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_vld", ov32, 0);
        check_eq("arst_sum", s32, 0);
        check_eq("arst_cout", co32, 0);
        check_eq("arst_ovf", of32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ov32) stale++;
        end
        check_eq("no_stale", stale, 0);
        check_eq("post_rst_rdy", ir32, 1);
        run_stream("post_rst", 1, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
